my_ram_64_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 64x16 RAM (my_ram_64). Accepts read/write requests from ports A and B over a valid/ready handshake, grants one at a time with round-robin fairness, drives the RAM's addr/in/load pins for exactly one access cycle and returns read data with a one-cycle response pulse. Sits between the two masters and a single my_ram_64 instance clocked on the same clk.

---
 rtl/my_ram_64_arbiter.sv | 91 +++++++++
 tb/tb_my_ram_64_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_ram_64_arbiter.sv
// my_ram_64_arbiter: round-robin two-port arbiter/sequencer in front of a 64x16 my_ram_64.
// Optional grant counters and conflict flag under `MY_RAM_64_ARB_STATS_EN.
module my_ram_64_arbiter #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  input  logic [DW-1:0] ram_out
`ifdef MY_RAM_64_ARB_STATS_EN
  ,
  output logic [15:0]   a_grants,
  output logic [15:0]   b_grants,
  output logic          conflict
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last_b, win_b, accept;
  // last_b doubles as the id of the in-flight transaction: it is updated exactly when a grant is latched
  assign win_b   = b_valid & (~a_valid | ~last_b);
  assign accept  = (state == IDLE) & (a_valid | b_valid);
  assign a_ready = rst_n & (state == IDLE) & a_valid & ~win_b;
  assign b_ready = rst_n & (state == IDLE) & win_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      ram_addr    <= '0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= ACCESS;
          last_b   <= win_b;
          ram_addr <= win_b ? b_addr : a_addr;
          ram_in   <= win_b ? b_wdata : a_wdata;
          ram_load <= win_b ? b_we : a_we;
        end
        ACCESS: begin
          state       <= RESP;
          ram_load    <= 1'b0;
          a_rsp_valid <= ~last_b;
          b_rsp_valid <= last_b;
          if (!ram_load && !last_b) a_rdata <= ram_out;
          if (!ram_load && last_b) b_rdata <= ram_out;
        end
        RESP: begin
          state       <= IDLE;
          a_rsp_valid <= 1'b0;
          b_rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MY_RAM_64_ARB_STATS_EN
  assign conflict = (state == IDLE) & a_valid & b_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grants <= '0;
      b_grants <= '0;
    end else if (accept) begin
      if (!win_b && a_grants != 16'hFFFF) a_grants <= a_grants + 16'd1;
      if (win_b && b_grants != 16'hFFFF) b_grants <= b_grants + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_my_ram_64_arbiter.sv
// tb_my_ram_64_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_my_ram_64_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [5:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic a_ready, a_rsp_valid, b_ready, b_rsp_valid, ram_load;
  logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
  logic [5:0] ram_addr;
`ifdef MY_RAM_64_ARB_STATS_EN
  logic [15:0] a_grants, b_grants;
  logic conflict;
  int m_ag = 0, m_bg = 0;
  bit seen_conflict = 0;
`endif
  int checks = 0, errs = 0;
  bit [15:0] ram [64];
  bit [15:0] m_mem [64];
  int ph = 0;
  bit m_last_b = 1, m_pb = 0, m_we = 0;
  logic [5:0] m_addr = 0;
  logic [15:0] m_wdata = 0, m_ard = 0, m_brd = 0;
  string glog = "";

  always #5 clk = ~clk;

  my_ram_64_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
`ifdef MY_RAM_64_ARB_STATS_EN
    , .a_grants(a_grants), .b_grants(b_grants), .conflict(conflict)
`endif
  );

  // the shared RAM the arbiter drives
  assign ram_out = ram[ram_addr];
  always @(posedge clk) if (ram_load) ram[ram_addr] <= ram_in;

  function automatic bit pick_b();
    if (a_valid && b_valid) return !m_last_b;
    return b_valid;
  endfunction

  // model: ph counts cycles since the accept (0 = idle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; m_last_b <= 1; m_ard <= 0; m_brd <= 0; m_addr <= 0; m_wdata <= 0; m_we <= 0;
`ifdef MY_RAM_64_ARB_STATS_EN
      m_ag <= 0; m_bg <= 0;
`endif
    end else if (ph == 0) begin
      if (a_valid || b_valid) begin
        ph <= 1;
        m_pb <= pick_b(); m_last_b <= pick_b();
        m_we <= pick_b() ? b_we : a_we;
        m_addr <= pick_b() ? b_addr : a_addr;
        m_wdata <= pick_b() ? b_wdata : a_wdata;
        glog <= {glog, pick_b() ? "B" : "A"};
`ifdef MY_RAM_64_ARB_STATS_EN
        if (pick_b()) m_bg <= (m_bg == 65535) ? m_bg : m_bg + 1;
        else m_ag <= (m_ag == 65535) ? m_ag : m_ag + 1;
`endif
      end
    end else if (ph == 1) begin
      ph <= 2;
      if (m_we) m_mem[m_addr] <= m_wdata;
      else if (m_pb) m_brd <= m_mem[m_addr];
      else m_ard <= m_mem[m_addr];
    end else ph <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ready", 32'(a_ready), 32'(rst_n && ph == 0 && a_valid && !pick_b()));
    chk("b_ready", 32'(b_ready), 32'(rst_n && ph == 0 && b_valid && pick_b()));
    chk("ram_load", 32'(ram_load), 32'(ph == 1 && m_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_in", 32'(ram_in), 32'(m_wdata));
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'(ph == 2 && !m_pb));
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(ph == 2 && m_pb));
    chk("a_rdata", 32'(a_rdata), 32'(m_ard));
    chk("b_rdata", 32'(b_rdata), 32'(m_brd));
`ifdef MY_RAM_64_ARB_STATS_EN
    chk("a_grants", 32'(a_grants), 32'(m_ag));
    chk("b_grants", 32'(b_grants), 32'(m_bg));
    chk("conflict", 32'(conflict), 32'(ph == 0 && a_valid && b_valid));
    if (conflict) seen_conflict = 1;
`endif
  end

  task automatic do_req(input bit pb, input bit we, input logic [5:0] addr, input logic [15:0] d);
    bit got = 0;
    int n = 0;
    if (pb) begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = d; end
    else begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = d; end
    while (!got && n < 50) begin
      @(negedge clk);
      got = pb ? b_ready : a_ready;
      n++;
    end
    if (!got) begin
      checks++; errs++;
      $display("FAIL handshake_timeout: port %s got no ready within %0d cycles", pb ? "B" : "A", n);
    end
    @(posedge clk); #1;
    if (pb) b_valid = 0; else a_valid = 0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    glog = "";
  endtask

  task automatic chk_log(input string nm, input string exp);
    checks++;
    if (glog != exp) begin
      errs++;
      $display("FAIL %s: got grants %s expected %s", nm, glog, exp);
    end
  endtask

  function automatic logic [5:0] rand_addr();
    return $urandom_range(1) ? 6'($urandom_range(3)) : 6'($urandom_range(63));
  endfunction

  initial begin
    bit ta, tb, da, db;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // write then read on A
    do_req(0, 1, 6'd0, 16'd2);
    do_req(0, 0, 6'd0, 16'd0);
    drain();
    chk("t1_a_rdata", 32'(a_rdata), 32'd2);
    // simultaneous writes after reset: A wins the tie
    do_reset();
    fork
      do_req(0, 1, 6'b010011, 16'd5);
      do_req(1, 1, 6'b100111, 16'd9);
    join
    drain();
    chk_log("t2_order", "AB");
    do_req(0, 0, 6'b010011, 16'd0);
    drain();
    chk("t2_read_a", 32'(a_rdata), 32'd5);
    do_req(0, 0, 6'b100111, 16'd0);
    drain();
    chk("t2_read_b", 32'(a_rdata), 32'd9);
    // continuous reads on both ports alternate
    do_reset();
    fork
      repeat (3) do_req(0, 0, 6'd0, 16'd0);
      repeat (3) do_req(1, 0, 6'd19, 16'd0);
    join
    drain();
    chk_log("t3_order", "ABABAB");
    chk("t3_a_rdata", 32'(a_rdata), 32'd2);
    chk("t3_b_rdata", 32'(b_rdata), 32'd5);
`ifdef MY_RAM_64_ARB_STATS_EN
    chk("t3_a_grants", 32'(a_grants), 32'd3);
    chk("t3_b_grants", 32'(b_grants), 32'd3);
    chk("t3_conflict_seen", 32'(seen_conflict), 32'd1);
`endif
    // B alone, back to back
    do_reset();
    do_req(1, 1, 6'b001100, 16'd6);
    repeat (3) do_req(1, 0, 6'b001100, 16'd0);
    drain();
    chk_log("t4_order", "BBBB");
    chk("t4_b_rdata", 32'(b_rdata), 32'd6);
    chk("t4_a_rdata", 32'(a_rdata), 32'd0);
    // reset in the middle of a write's ACCESS cycle
    do_req(0, 1, 6'b010101, 16'h1234);
    drain();
    a_valid = 1; a_we = 1; a_addr = 6'b010101; a_wdata = 16'd7;
    @(negedge clk);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk); #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_req(0, 0, 6'b010101, 16'd0);
    drain();
    chk("t5_old_value", 32'(a_rdata), 32'h1234);
    do_reset();
    @(negedge clk);
`ifdef MY_RAM_64_ARB_STATS_EN
    chk("t6_a_grants_rst", 32'(a_grants), 32'd0);
    chk("t6_b_grants_rst", 32'(b_grants), 32'd0);
`endif
    chk("t6_a_rdata_rst", 32'(a_rdata), 32'd0);
    // random traffic with occasional withdrawals
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ta = a_valid & a_ready;
      tb = b_valid & b_ready;
      da = a_valid && !a_ready && $urandom_range(15) == 0;
      db = b_valid && !b_ready && $urandom_range(15) == 0;
      @(posedge clk); #1;
      if (ta || da) a_valid = 0;
      if (tb || db) b_valid = 0;
      if (!a_valid && $urandom_range(2) != 0) begin
        a_valid = 1; a_we = 1'($urandom_range(1)); a_addr = rand_addr(); a_wdata = 16'($urandom);
      end
      if (!b_valid && $urandom_range(2) != 0) begin
        b_valid = 1; b_we = 1'($urandom_range(1)); b_addr = rand_addr(); b_wdata = 16'($urandom);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
